// File: rtl/byte_data_memory_if.sv
// Load/store bus between the MEM stage and byte_data_memory.
// The master drives address, data and control; the memory returns load data, fault and busy.
interface byte_data_memory_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           write_data;
    logic                  mem_read;
    logic                  mem_write;
    logic [1:0]            size;
    logic                  load_unsigned;
    logic [31:0]           read_data;
    logic                  fault;
    logic                  busy;

    modport master (
        output addr, write_data, mem_read, mem_write, size, load_unsigned,
        input  read_data, fault, busy
    );

    modport slave (
        input  addr, write_data, mem_read, mem_write, size, load_unsigned,
        output read_data, fault, busy
    );
endinterface

// File: rtl/byte_data_memory.sv
// Little-endian byte/half/word data memory with alignment and range checking,
// and a one-word-per-cycle clear sweep after reset.
//
// state   | meaning
// S_CLEAR | sweeping mem[clr_ptr] <= 0 each edge, busy = 1, accesses blocked
// S_READY | normal load/store operation, left only by reset
module byte_data_memory #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    byte_data_memory_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-2:0] DEPTH_L  = (ADDR_WIDTH-1)'(DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PTR_W-1:0]    r_clr_ptr;
    logic [PTR_W-1:0]    w_clr_ptr_next;
    logic [31:0]         r_mem [DEPTH];

    logic [ADDR_WIDTH-3:0] w_idx;
    logic [1:0]            w_off;
    logic [PTR_W-1:0]      w_word;
    logic                  w_busy;
    logic                  w_access;
    logic                  w_fault;
    logic                  w_wr_en;
    logic [31:0]           w_rd_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_read_data;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;

    assign w_idx    = bus.addr[ADDR_WIDTH-1:2];
    assign w_off    = bus.addr[1:0];
    assign w_word   = w_idx[PTR_W-1:0];
    assign w_busy   = (r_state == S_CLEAR);
    assign w_access = bus.mem_read | bus.mem_write;

    assign w_fault = w_access & ((bus.size == 2'b11) |
                                 ((bus.size == 2'b01) & w_off[0]) |
                                 ((bus.size == 2'b10) & (w_off != 2'b00)) |
                                 ({1'b0, w_idx} >= DEPTH_L));

    assign w_wr_en = bus.mem_write & ~w_fault & ~w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            S_CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == LAST_PTR) begin
                    w_next_state   = S_READY;
                    w_clr_ptr_next = '0;
                end
            end
            default: ;
        endcase
    end

    // Sub-word stores replicate the source so each enabled lane finds its byte in place.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.write_data;
        case (bus.size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.write_data[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (w_be[n]) begin
                    r_mem[w_word][8*n +: 8] <= w_wdata[8*n +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_word];
    assign w_byte    = w_rd_word[8*w_off +: 8];
    assign w_half    = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_read_data = '0;
        if (bus.mem_read && !w_busy && !w_fault) begin
            case (bus.size)
                2'b00:   w_read_data = {{24{w_byte[7] & ~bus.load_unsigned}}, w_byte};
                2'b01:   w_read_data = {{16{w_half[15] & ~bus.load_unsigned}}, w_half};
                2'b10:   w_read_data = w_rd_word;
                default: w_read_data = '0;
            endcase
        end
    end

    assign bus.read_data = w_read_data;
    assign bus.fault     = w_fault;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_byte_data_memory.sv
// Scoreboard bench for byte_data_memory: a 64-word instance for the main checks
// and a 48-word instance for range faults; expectations are queued and checked on negedge.
module tb_byte_data_memory;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    byte_data_memory_if #(.ADDR_WIDTH(8)) bus_a ();
    byte_data_memory_if #(.ADDR_WIDTH(8)) bus_b ();

    byte_data_memory #(.ADDR_WIDTH(8), .DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    byte_data_memory #(.ADDR_WIDTH(8), .DEPTH(48), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] rd;
        logic        flt;
        logic        bsy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    exp_t mon_e;
    logic [31:0] mon_rd;
    logic        mon_flt;
    logic        mon_bsy;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_rd  = (mon_e.dut == 0) ? bus_a.read_data : bus_b.read_data;
            mon_flt = (mon_e.dut == 0) ? bus_a.fault     : bus_b.fault;
            mon_bsy = (mon_e.dut == 0) ? bus_a.busy      : bus_b.busy;
            checks++;
            if (mon_rd !== mon_e.rd || mon_flt !== mon_e.flt || mon_bsy !== mon_e.bsy) begin
                errors++;
                $display("FAIL %s: got read_data=%h fault=%b busy=%b, expected read_data=%h fault=%b busy=%b",
                         mon_e.name, mon_rd, mon_flt, mon_bsy, mon_e.rd, mon_e.flt, mon_e.bsy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, expv, expv);
        end
    endtask

    task automatic idle();
        bus_a.addr = '0; bus_a.write_data = '0; bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0;
        bus_a.size = 2'b00; bus_a.load_unsigned = 1'b0;
        bus_b.addr = '0; bus_b.write_data = '0; bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0;
        bus_b.size = 2'b00; bus_b.load_unsigned = 1'b0;
    endtask

    task automatic drive(input int dut, input logic [7:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic [1:0] sz, input logic lu);
        idle();
        if (dut == 0) begin
            bus_a.addr = a; bus_a.write_data = wd; bus_a.mem_read = rd; bus_a.mem_write = wr;
            bus_a.size = sz; bus_a.load_unsigned = lu;
        end else begin
            bus_b.addr = a; bus_b.write_data = wd; bus_b.mem_read = rd; bus_b.mem_write = wr;
            bus_b.size = sz; bus_b.load_unsigned = lu;
        end
    endtask

    task automatic push(input string name, input int dut, input logic [31:0] rd,
                        input logic flt, input logic bsy);
        exp_t e;
        e.name = name; e.dut = dut; e.rd = rd; e.flt = flt; e.bsy = bsy;
        q.push_back(e);
    endtask

    // One access per cycle: drive after the edge, queue the expectation, let the monitor sample at negedge.
    task automatic vec(input string name, input int dut, input logic [7:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic lu,
                       input logic [31:0] exp_rd, input logic exp_flt, input logic exp_bsy);
        @(posedge clk); #1;
        drive(dut, a, wd, rd, wr, sz, lu);
        push(name, dut, exp_rd, exp_flt, exp_bsy);
        @(negedge clk);
    endtask

    task automatic st(input string name, input int dut, input logic [7:0] a,
                      input logic [31:0] d, input logic [1:0] sz);
        vec(name, dut, a, d, 1'b0, 1'b1, sz, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic ld(input string name, input int dut, input logic [7:0] a,
                      input logic [1:0] sz, input logic lu, input logic [31:0] expv);
        vec(name, dut, a, 32'h0, 1'b1, 1'b0, sz, lu, expv, 1'b0, 1'b0);
    endtask

    // Releases reset and counts edges until each instance drops busy; -1 means it never did.
    task automatic sweep(output int na, output int nb);
        na = -1;
        nb = -1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 5) push("busy_midsweep", 0, 32'h0, 1'b0, 1'b1);
            if (nb < 0 && !bus_b.busy) nb = n;
            if (na < 0 && !bus_a.busy) begin
                na = n;
                break;
            end
        end
    endtask

    int na, nb;

    initial begin
        idle();
        bus_a.mem_read = 1'b1;
        bus_a.size     = 2'b10;
        #2;
        chk("busy_at_reset", 32'(bus_a.busy), 32'd1);
        chk("read_zero_at_reset", bus_a.read_data, 32'h0);
        #20;
        sweep(na, nb);
        chk("sweep_edges_a", na, 64);
        chk("sweep_edges_b", nb, 48);
        idle();

        for (int i = 0; i < 64; i++) begin
            ld("cleared_word", 0, 8'(i * 4), 2'b10, 1'b0, 32'h0);
        end

        st("store_10", 0, 8'h10, 32'h80F1_7F02, 2'b10);
        ld("byte3_signed",   0, 8'h13, 2'b00, 1'b0, 32'hFFFF_FF80);
        ld("byte3_unsigned", 0, 8'h13, 2'b00, 1'b1, 32'h0000_0080);
        ld("half2_signed",   0, 8'h12, 2'b01, 1'b0, 32'hFFFF_80F1);
        ld("byte1",          0, 8'h11, 2'b00, 1'b0, 32'h0000_007F);
        ld("byte0_unsigned", 0, 8'h10, 2'b00, 1'b1, 32'h0000_0002);
        ld("half0_unsigned", 0, 8'h10, 2'b01, 1'b1, 32'h0000_7F02);
        ld("half2_unsigned", 0, 8'h12, 2'b01, 1'b1, 32'h0000_80F1);
        ld("word_10",        0, 8'h10, 2'b10, 1'b0, 32'h80F1_7F02);

        st("store_20_zero", 0, 8'h20, 32'h0, 2'b10);
        st("store_22_half", 0, 8'h22, 32'h1234_BEEF, 2'b01);
        st("store_20_byte", 0, 8'h20, 32'hFFFF_FF5A, 2'b00);
        ld("lane_isolation", 0, 8'h20, 2'b10, 1'b0, 32'hBEEF_005A);

        vec("fault_half_21",  0, 8'h21, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
        vec("fault_word_22",  0, 8'h22, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0);
        vec("fault_size3_24", 0, 8'h24, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0);
        vec("fault_load_21",  0, 8'h21, 32'h0,         1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
        vec("idle_no_fault",  0, 8'h21, 32'h0,         1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 1'b0);
        ld("after_faults_20", 0, 8'h20, 2'b10, 1'b0, 32'hBEEF_005A);
        ld("after_faults_24", 0, 8'h24, 2'b10, 1'b0, 32'h0);

        vec("oor_store_c0", 1, 8'hC0, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0);
        vec("oor_load_c0",  1, 8'hC0, 32'h0,         1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0);
        vec("oor_byte_fd",  1, 8'hFD, 32'h0,         1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0);
        st("last_word_b",   1, 8'hBC, 32'h1234_5678, 2'b10);
        ld("last_word_b_rd", 1, 8'hBC, 2'b10, 1'b0, 32'h1234_5678);
        ld("b_word0_clean",  1, 8'h00, 2'b10, 1'b0, 32'h0);

        st("store_08", 0, 8'h08, 32'h1111_1111, 2'b10);
        vec("rdw_before", 0, 8'h08, 32'h2222_2222, 1'b1, 1'b1, 2'b10, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
        ld("rdw_after", 0, 8'h08, 2'b10, 1'b0, 32'h2222_2222);
        st("store_04", 0, 8'h04, 32'h5555_5555, 2'b10);

        @(negedge clk);
        drive(0, 8'h04, 32'hAAAA_AAAA, 1'b1, 1'b1, 2'b10, 1'b0);
        reset = 1'b1;
        #1;
        chk("busy_on_reset_assert", 32'(bus_a.busy), 32'd1);
        chk("busy_read_zero", bus_a.read_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("busy_after_20_edges", 32'(bus_a.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("busy_on_mid_reset", 32'(bus_a.busy), 32'd1);
        sweep(na, nb);
        chk("restart_sweep_edges_a", na, 64);
        idle();
        ld("busy_store_dropped", 0, 8'h04, 2'b10, 1'b0, 32'h0);
        ld("recleared_08",       0, 8'h08, 2'b10, 1'b0, 32'h0);
        ld("recleared_20",       0, 8'h20, 2'b10, 1'b0, 32'h0);
        ld("recleared_fc",       0, 8'hFC, 2'b10, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
